// File: rtl/sobol_gen_multi.sv
// Multi-dimension Sobol sequence generator: Gray-code XOR update per dimension,
// run-time loadable direction numbers, valid/ready output with optional skip and one-shot mode.
module sobol_gen_multi #(
   parameter int WIDTH = 6,
   parameter int DIMS  = 2,
   parameter int SKIP  = 0,
   parameter int WRAP  = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          dir_load,
   input  logic [DIMS*WIDTH*WIDTH-1:0]   dir_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DIMS*WIDTH-1:0]         out_data,
   output logic [WIDTH-1:0]              out_index,
   output logic                          out_last,
   output logic                          busy
);

   localparam int VW = WIDTH * WIDTH;
   localparam logic [WIDTH-1:0] IDX_MAX   = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] SKIP_LAST = WIDTH'(SKIP - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SKIP = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                    state_r, state_n;
   logic [WIDTH-1:0]          idx_r, idx_n;
   logic [DIMS*WIDTH-1:0]     x_r, x_n;
   logic [DIMS*VW-1:0]        dir_r;
   logic                      out_valid_r, out_last_r, busy_r;
   logic                      xfer_s;

   // Next point: XOR in V[c] where c is the lowest zero bit of idx; the last index wraps to x=0.
   function automatic logic [DIMS*WIDTH-1:0] next_point(
      input logic [DIMS*WIDTH-1:0] x,
      input logic [WIDTH-1:0]      idx,
      input logic [DIMS*VW-1:0]    dir
   );
      logic [WIDTH-1:0]      sel;
      logic [DIMS*WIDTH-1:0] nx;
      sel = ~idx & (idx + WIDTH'(1));
      nx  = x;
      for (int d = 0; d < DIMS; d++) begin
         for (int k = 0; k < WIDTH; k++) begin
            nx[d*WIDTH +: WIDTH] = nx[d*WIDTH +: WIDTH] ^
                                   (dir[d*VW + k*WIDTH +: WIDTH] & {WIDTH{sel[k]}});
         end
      end
      return (idx == IDX_MAX) ? {(DIMS*WIDTH){1'b0}} : nx;
   endfunction

   assign xfer_s    = out_valid_r && out_ready;
   assign out_valid = out_valid_r;
   assign out_last  = out_last_r;
   assign busy      = busy_r;
   assign out_data  = x_r;
   assign out_index = idx_r;

   // Next-state and next-point selection
   always_comb begin
      state_n = state_r;
      idx_n   = idx_r;
      x_n     = x_r;
      case (state_r)
         ST_IDLE: begin
            idx_n = {WIDTH{1'b0}};
            x_n   = {(DIMS*WIDTH){1'b0}};
            if (en) begin
               state_n = (SKIP > 0) ? ST_SKIP : ST_RUN;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_SKIP: begin
            if (en) begin
               idx_n = idx_r + WIDTH'(1);
               x_n   = next_point(x_r, idx_r, dir_r);
               if (idx_r == SKIP_LAST) begin
                  state_n = ST_RUN;
               end else begin
                  state_n = ST_SKIP;
               end
            end else begin
               state_n = ST_IDLE;
               idx_n   = {WIDTH{1'b0}};
               x_n     = {(DIMS*WIDTH){1'b0}};
            end
         end
         ST_RUN: begin
            if (!en) begin
               state_n = ST_IDLE;
               idx_n   = {WIDTH{1'b0}};
               x_n     = {(DIMS*WIDTH){1'b0}};
            end else if (xfer_s) begin
               idx_n = idx_r + WIDTH'(1);
               x_n   = next_point(x_r, idx_r, dir_r);
               if ((idx_r == IDX_MAX) && (WRAP == 0)) begin
                  state_n = ST_DONE;
               end else begin
                  state_n = ST_RUN;
               end
            end else begin
               state_n = ST_RUN;
            end
         end
         ST_DONE: begin
            idx_n = {WIDTH{1'b0}};
            x_n   = {(DIMS*WIDTH){1'b0}};
            if (en) begin
               state_n = ST_DONE;
            end else begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
            idx_n   = {WIDTH{1'b0}};
            x_n     = {(DIMS*WIDTH){1'b0}};
         end
      endcase
   end

   // State, point and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         idx_r       <= {WIDTH{1'b0}};
         x_r         <= {(DIMS*WIDTH){1'b0}};
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= state_n;
         idx_r       <= idx_n;
         x_r         <= x_n;
         out_valid_r <= (state_n == ST_RUN);
         out_last_r  <= (state_n == ST_RUN) && (idx_n == IDX_MAX);
         busy_r      <= (state_n == ST_SKIP) || (state_n == ST_RUN);
      end
   end

   // Direction numbers are only writable while idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_r <= {(DIMS*VW){1'b0}};
      end else if ((state_r == ST_IDLE) && dir_load) begin
         dir_r <= dir_in;
      end
   end

endmodule
